// File: rtl/tlp_cap_ctrl.sv
// tlp_cap_ctrl: capture sequencer for the TLP debug RAM on the TRN clock.
//
// Once armed, every accepted stream beat is recorded into a circular window of
// 2**ADDR_W entries. A trigger beat is chosen by a header match, immediately, or
// by force. After the trigger, post_cnt more beats are recorded and capture stops.
//
// Ports:
//   trn_clk, trn_rst_n      clock and asynchronous active-low reset
//   st_valid0 .. st_data0   stream input; a beat is accepted when valid & ready
//   arm, abort, force_trig  control pulses
//   trig_mode               0 = trigger on first beat, 1 = header match
//   trig_mask, trig_value   match on st_data0[31:0] of a SOP beat
//   post_cnt                beats recorded after the trigger beat
//   cap_wr_en/addr/data     registered RAM write port; data = {data, be, sop, eop}
//   cap_state, cap_done     0 idle, 1 armed, 2 post, 3 done; done flag
//   cap_wrapped             write pointer wrapped since the last arm
//   trig_addr               RAM address holding the trigger beat
module tlp_cap_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BE_W   = 8
) (
  input  logic                     trn_clk,
  input  logic                     trn_rst_n,
  input  logic                     st_valid0,
  input  logic                     st_ready0,
  input  logic                     st_sop0,
  input  logic                     st_eop0,
  input  logic [BE_W-1:0]          st_be0,
  input  logic [DATA_W-1:0]        st_data0,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     force_trig,
  input  logic                     trig_mode,
  input  logic [31:0]              trig_mask,
  input  logic [31:0]              trig_value,
  input  logic [ADDR_W-1:0]        post_cnt,
  output logic                     cap_wr_en,
  output logic [ADDR_W-1:0]        cap_wr_addr,
  output logic [DATA_W+BE_W+1:0]   cap_wr_data,
  output logic [1:0]               cap_state,
  output logic                     cap_done,
  output logic                     cap_wrapped,
  output logic [ADDR_W-1:0]        trig_addr
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              force_pend_q;

  logic beat;
  logic hdr_match;
  logic trig_hit;
  logic wr_now;

  assign beat      = st_valid0 & st_ready0;
  assign hdr_match = st_sop0 & (((st_data0[31:0] ^ trig_value) & trig_mask) == 32'h0);
  // A force pulse arriving together with a beat triggers on that same beat.
  assign trig_hit  = beat & (force_pend_q | force_trig | ~trig_mode | hdr_match);
  // abort suppresses the write of a beat accepted in the same cycle.
  assign wr_now    = beat & ~abort & ((state_q == StArmed) | (state_q == StPost));

  assign cap_state = state_q;
  assign cap_done  = (state_q == StDone);

  always_ff @(posedge trn_clk or negedge trn_rst_n) begin
    if (!trn_rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      remaining_q  <= '0;
      force_pend_q <= 1'b0;
      cap_wr_en    <= 1'b0;
      cap_wr_addr  <= '0;
      cap_wr_data  <= '0;
      cap_wrapped  <= 1'b0;
      trig_addr    <= '0;
    end else begin
      cap_wr_en <= wr_now;
      if (wr_now) begin
        cap_wr_addr <= ptr_q;
        cap_wr_data <= {st_data0, st_be0, st_sop0, st_eop0};
        ptr_q       <= ptr_q + ADDR_W'(1);
        if (&ptr_q) begin
          cap_wrapped <= 1'b1;
        end
      end

      if (force_trig) begin
        force_pend_q <= 1'b1;
      end

      if (abort) begin
        state_q      <= StIdle;
        force_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (arm) begin
              state_q      <= StArmed;
              ptr_q        <= '0;
              cap_wrapped  <= 1'b0;
              trig_addr    <= '0;
              force_pend_q <= 1'b0;
            end
          end
          StArmed: begin
            if (trig_hit) begin
              trig_addr    <= ptr_q;
              force_pend_q <= 1'b0;
              if (post_cnt == '0) begin
                state_q <= StDone;
              end else begin
                state_q     <= StPost;
                remaining_q <= post_cnt;
              end
            end
          end
          StPost: begin
            if (beat) begin
              remaining_q <= remaining_q - ADDR_W'(1);
              if (remaining_q == ADDR_W'(1)) begin
                state_q <= StDone;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlp_cap_ctrl.sv
// tb_tlp_cap_ctrl: table-driven bench for tlp_cap_ctrl with a 16-entry window.
// Each vector drives one cycle of inputs and lists the outputs expected just after
// the following rising edge; wrap, force and reset corners are hand sequences.
module tb_tlp_cap_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;
  localparam logic [31:0] MatchHdr = 32'h4A00_0001;
  localparam logic [31:0] MissHdr  = 32'h4A00_0000;

  logic              trn_clk;
  logic              trn_rst_n;
  logic              st_valid0, st_ready0, st_sop0, st_eop0;
  logic [BW-1:0]     st_be0;
  logic [DW-1:0]     st_data0;
  logic              arm, abort, force_trig, trig_mode;
  logic [31:0]       trig_mask, trig_value;
  logic [AW-1:0]     post_cnt;
  logic              cap_wr_en;
  logic [AW-1:0]     cap_wr_addr;
  logic [DW+BW+1:0]  cap_wr_data;
  logic [1:0]        cap_state;
  logic              cap_done;
  logic              cap_wrapped;
  logic [AW-1:0]     trig_addr;

  int n_cmp;
  int n_fail;

  tlp_cap_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .BE_W   (BW)
  ) dut (
    .trn_clk     (trn_clk),
    .trn_rst_n   (trn_rst_n),
    .st_valid0   (st_valid0),
    .st_ready0   (st_ready0),
    .st_sop0     (st_sop0),
    .st_eop0     (st_eop0),
    .st_be0      (st_be0),
    .st_data0    (st_data0),
    .arm         (arm),
    .abort       (abort),
    .force_trig  (force_trig),
    .trig_mode   (trig_mode),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .post_cnt    (post_cnt),
    .cap_wr_en   (cap_wr_en),
    .cap_wr_addr (cap_wr_addr),
    .cap_wr_data (cap_wr_data),
    .cap_state   (cap_state),
    .cap_done    (cap_done),
    .cap_wrapped (cap_wrapped),
    .trig_addr   (trig_addr)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic          valid, ready, sop;
    logic [31:0]   d;
    logic          arm, abort, frc, mode;
    logic [AW-1:0] post;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_st;
    logic          exp_wrap;
    logic [AW-1:0] exp_trig;
  } vec_t;

  function automatic vec_t v(input logic va, re, so, input logic [31:0] d,
                             input logic ar, ab, fr, mo, input logic [AW-1:0] pc,
                             input logic ew, input logic [AW-1:0] ea,
                             input logic [1:0] es, input logic ewr,
                             input logic [AW-1:0] et);
    vec_t r;
    r.valid = va; r.ready = re; r.sop = so; r.d = d;
    r.arm = ar; r.abort = ab; r.frc = fr; r.mode = mo; r.post = pc;
    r.exp_wr = ew; r.exp_addr = ea; r.exp_st = es; r.exp_wrap = ewr; r.exp_trig = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then check outputs 1 time unit after the rising edge.
  task automatic run_vec(input vec_t r, input string tag);
    logic [DW+BW+1:0] exp_data;
    st_valid0  = r.valid;
    st_ready0  = r.ready;
    st_sop0    = r.sop;
    st_eop0    = r.d[0];
    st_be0     = r.d[7:0] ^ 8'h5A;
    st_data0   = {~r.d, r.d};
    arm        = r.arm;
    abort      = r.abort;
    force_trig = r.frc;
    trig_mode  = r.mode;
    post_cnt   = r.post;
    exp_data   = {~r.d, r.d, r.d[7:0] ^ 8'h5A, r.sop, r.d[0]};
    @(posedge trn_clk);
    #1;
    chk({tag, " wr_en"},     128'(cap_wr_en),   128'(r.exp_wr));
    chk({tag, " state"},     128'(cap_state),   128'(r.exp_st));
    chk({tag, " done"},      128'(cap_done),    128'(r.exp_st == 2'd3));
    chk({tag, " wrapped"},   128'(cap_wrapped), 128'(r.exp_wrap));
    chk({tag, " trig_addr"}, 128'(trig_addr),   128'(r.exp_trig));
    if (r.exp_wr) begin
      chk({tag, " wr_addr"}, 128'(cap_wr_addr), 128'(r.exp_addr));
      chk({tag, " wr_data"}, 128'(cap_wr_data), 128'(exp_data));
    end
  endtask

  vec_t tbl[$];

  initial begin
    n_cmp = 0; n_fail = 0;
    trn_rst_n = 1'b0;
    st_valid0 = 0; st_ready0 = 0; st_sop0 = 0; st_eop0 = 0; st_be0 = '0; st_data0 = '0;
    arm = 0; abort = 0; force_trig = 0; trig_mode = 0; post_cnt = '0;
    trig_mask = 32'hFFFF_FFFF;
    trig_value = MatchHdr;

    // 1: first-beat trigger, post_cnt=3 -> four writes then DONE, fifth ignored.
    tbl.push_back(v(0,0,0,32'h0,     1,0,0,0,4'd3, 0,4'd0,2'd1,0,4'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1,1,1,32'h100 + i, 0,0,0,0,4'd3, 1,AW'(i),(i == 3) ? 2'd3 : 2'd2,0,4'd0));
    tbl.push_back(v(1,1,1,32'h200,   0,0,0,0,4'd3, 0,4'd0,2'd3,0,4'd0));
    // 2: header match after ten misses; arm while ARMED is ignored.
    tbl.push_back(v(0,0,0,32'h0,     1,0,0,1,4'd5, 0,4'd0,2'd1,0,4'd0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(1,1,1,MissHdr, (i == 5),0,0,1,4'd5, 1,AW'(i),2'd1,0,4'd0));
    tbl.push_back(v(1,1,1,MatchHdr,  0,0,0,1,4'd5, 1,4'd10,2'd2,0,4'd10));
    // Abort in POST drops the concurrent beat.
    tbl.push_back(v(1,1,1,MatchHdr,  0,1,0,1,4'd5, 0,4'd0,2'd0,0,4'd10));
    // 4: non-SOP match and stalled match do not trigger; accepted match does.
    tbl.push_back(v(0,0,0,32'h0,     1,0,0,1,4'd2, 0,4'd0,2'd1,0,4'd0));
    tbl.push_back(v(1,1,0,MatchHdr,  0,0,0,1,4'd2, 1,4'd0,2'd1,0,4'd0));
    tbl.push_back(v(1,1,1,MissHdr,   0,0,0,1,4'd2, 1,4'd1,2'd1,0,4'd0));
    tbl.push_back(v(1,0,1,MatchHdr,  0,0,0,1,4'd2, 0,4'd0,2'd1,0,4'd0));
    tbl.push_back(v(1,1,1,MatchHdr,  0,0,0,1,4'd2, 1,4'd2,2'd2,0,4'd2));
    tbl.push_back(v(1,1,0,32'h33,    0,0,0,1,4'd2, 1,4'd3,2'd2,0,4'd2));
    tbl.push_back(v(1,1,0,32'h44,    0,0,0,1,4'd2, 1,4'd4,2'd3,0,4'd2));
    tbl.push_back(v(0,0,0,32'h0,     0,0,0,1,4'd2, 0,4'd0,2'd3,0,4'd2));
    // 5: abort + arm + beat in POST -> IDLE, nothing written; IDLE beats ignored.
    tbl.push_back(v(0,0,0,32'h0,     1,0,0,0,4'd5, 0,4'd0,2'd1,0,4'd0));
    tbl.push_back(v(1,1,1,32'h55,    0,0,0,0,4'd5, 1,4'd0,2'd2,0,4'd0));
    tbl.push_back(v(1,1,0,32'h66,    0,0,0,0,4'd5, 1,4'd1,2'd2,0,4'd0));
    tbl.push_back(v(1,1,1,32'h77,    1,1,0,0,4'd5, 0,4'd0,2'd0,0,4'd0));
    tbl.push_back(v(1,1,1,32'h88,    0,0,0,0,4'd5, 0,4'd0,2'd0,0,4'd0));

    #12;
    chk("reset wr_en", 128'(cap_wr_en), 128'(0));
    chk("reset state", 128'(cap_state), 128'(0));
    chk("reset wrapped", 128'(cap_wrapped), 128'(0));
    @(negedge trn_clk);
    trn_rst_n = 1'b1;
    @(posedge trn_clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // 3: no trigger for 20 beats -> pointer wraps 15->0; then force + beat at 4.
    run_vec(v(0,0,0,32'h0, 1,0,0,1,4'd2, 0,4'd0,2'd1,0,4'd0), "wrap arm");
    for (int i = 0; i < 20; i++)
      run_vec(v(1,1,1,MissHdr, 0,0,0,1,4'd2, 1,AW'(i % 16),2'd1,(i >= 15),4'd0),
              $sformatf("wrap beat%0d", i));
    run_vec(v(0,0,0,32'h0,   0,0,1,1,4'd2, 0,4'd0,2'd1,1,4'd0), "force");
    run_vec(v(1,1,1,MissHdr, 0,0,0,1,4'd2, 1,4'd4,2'd2,1,4'd4), "force beat");

    // 6: asynchronous reset in POST clears all outputs without a clock edge.
    #2;
    trn_rst_n = 1'b0;
    #1;
    chk("async wr_en", 128'(cap_wr_en), 128'(0));
    chk("async wr_addr", 128'(cap_wr_addr), 128'(0));
    chk("async wr_data", 128'(cap_wr_data), 128'(0));
    chk("async state", 128'(cap_state), 128'(0));
    chk("async done", 128'(cap_done), 128'(0));
    chk("async wrapped", 128'(cap_wrapped), 128'(0));
    chk("async trig_addr", 128'(trig_addr), 128'(0));
    @(negedge trn_clk);
    trn_rst_n = 1'b1;
    run_vec(v(0,0,0,32'h0,   1,0,0,0,4'd2, 0,4'd0,2'd1,0,4'd0), "post-rst arm");
    run_vec(v(1,1,1,32'h99,  0,0,0,0,4'd2, 1,4'd0,2'd2,0,4'd0), "post-rst beat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
